alu_writeback: RTL and testbench

- Sequential stage directly downstream of the 16-way ALU result multiplexer.
- Captures the selected 8-bit result into accumulator A or operand register B and maintains zero/negative flags.
- Executes the register-moving ops STO and SWP, which the combinational mux cannot perform.
- A and B feed back to the ALU operand inputs; a valid/ready handshake paces the upstream sequencer.

---
 rtl/alu_writeback.sv | 89 ++++++++
 tb/tb_alu_writeback.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_writeback.sv
// Writeback stage behind the ALU result mux: commits results into A/B, keeps Z/N flags,
// and performs the register-moving ops STO and SWP that the mux cannot express.
module alu_writeback #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       opcode,
    input  logic             load,
    input  logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] reg_a,
    output logic [WIDTH-1:0] reg_b,
    output logic             flag_z,
    output logic             flag_n,
    output logic             done
);

    localparam logic [3:0] OP_CMP = 4'b0100;
    localparam logic [3:0] OP_STO = 4'b1110;
    localparam logic [3:0] OP_SWP = 4'b1111;

    typedef enum logic {
        IDLE  = 1'b0,
        SWAP2 = 1'b1
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] temp;

    // Ready depends on state alone so upstream never sees a loop through in_valid.
    assign in_ready = (state == IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            reg_a  <= '0;
            reg_b  <= '0;
            temp   <= '0;
            flag_z <= 1'b1;
            flag_n <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        if (load) begin
                            reg_a <= result;
                            done  <= 1'b1;
                        end else begin
                            case (opcode)
                                OP_CMP: begin
                                    flag_z <= (result == '0);
                                    flag_n <= result[WIDTH-1];
                                    done   <= 1'b1;
                                end
                                OP_STO: begin
                                    reg_b <= reg_a;
                                    done  <= 1'b1;
                                end
                                OP_SWP: begin
                                    // First half of the swap; done waits for reg_b to commit.
                                    temp  <= reg_a;
                                    reg_a <= reg_b;
                                    state <= SWAP2;
                                end
                                default: begin
                                    reg_a  <= result;
                                    flag_z <= (result == '0);
                                    flag_n <= result[WIDTH-1];
                                    done   <= 1'b1;
                                end
                            endcase
                        end
                    end
                end
                SWAP2: begin
                    reg_b <= temp;
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_writeback.sv
// Directed bench for alu_writeback: a reference model pushes expected state per transaction,
// and a monitor pops and compares it on every done pulse.
module tb_alu_writeback;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [3:0]       opcode = 4'b0000;
    logic             load = 1'b0;
    logic [WIDTH-1:0] result = '0;
    logic [WIDTH-1:0] reg_a;
    logic [WIDTH-1:0] reg_b;
    logic             flag_z;
    logic             flag_n;
    logic             done;

    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             z;
        logic             n;
    } exp_t;

    exp_t sb[$];
    logic [WIDTH-1:0] ma = '0;
    logic [WIDTH-1:0] mb = '0;
    logic             mz = 1'b1;
    logic             mn = 1'b0;
    int checks = 0;
    int errors = 0;
    int txn = 0;

    alu_writeback #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .load(load), .result(result), .reg_a(reg_a), .reg_b(reg_b),
        .flag_z(flag_z), .flag_n(flag_n), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference model: applies one accepted transaction and records the committed state.
    task automatic model_push(input logic ld, input logic [3:0] op, input logic [WIDTH-1:0] res);
        logic [WIDTH-1:0] t;
        if (ld) begin
            ma = res;
        end else begin
            case (op)
                4'b0100: begin mz = (res == 0); mn = res[WIDTH-1]; end
                4'b1110: mb = ma;
                4'b1111: begin t = ma; ma = mb; mb = t; end
                default: begin ma = res; mz = (res == 0); mn = res[WIDTH-1]; end
            endcase
        end
        sb.push_back('{a: ma, b: mb, z: mz, n: mn});
    endtask

    // Presents a transaction at the next negedge once in_ready is high; leaves in_valid asserted.
    task automatic issue(input logic ld, input logic [3:0] op, input logic [WIDTH-1:0] res);
        @(negedge clk);
        for (int k = 0; k < 8 && !in_ready; k++) @(negedge clk);
        check("issue_ready", in_ready, 1);
        in_valid = 1'b1;
        load     = ld;
        opcode   = op;
        result   = res;
        model_push(ld, op, res);
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
        load     = 1'b0;
    endtask

    // Scoreboard monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && done) begin
            txn++;
            if (sb.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                e = sb.pop_front();
                $display("txn %0d: a=%02h b=%02h z=%0b n=%0b (exp a=%02h b=%02h z=%0b n=%0b)",
                         txn, reg_a, reg_b, flag_z, flag_n, e.a, e.b, e.z, e.n);
                check("sb_reg_a", reg_a, e.a);
                check("sb_reg_b", reg_b, e.b);
                check("sb_flag_z", flag_z, e.z);
                check("sb_flag_n", flag_n, e.n);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset then idle
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        check("rst_reg_a", reg_a, 8'h00);
        check("rst_reg_b", reg_b, 8'h00);
        check("rst_flag_z", flag_z, 1);
        check("rst_flag_n", flag_n, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_done", done, 0);

        // ADD write with negative result; done is a single-cycle pulse
        issue(1'b0, 4'b0000, 8'h85);
        idle();
        check("add_reg_a", reg_a, 8'h85);
        check("add_flag_z", flag_z, 0);
        check("add_flag_n", flag_n, 1);
        check("add_done", done, 1);
        @(negedge clk);
        check("add_done_low", done, 0);

        // Load (opcode ignored, flags unchanged) then STO, back to back
        issue(1'b1, 4'b0100, 8'h0C);
        issue(1'b0, 4'b1110, 8'h99);
        idle();
        check("sto_reg_a", reg_a, 8'h0C);
        check("sto_reg_b", reg_b, 8'h0C);
        check("sto_flag_n", flag_n, 1);

        // SWP handshake with an ADD queued behind it
        issue(1'b1, 4'b0000, 8'h34);
        issue(1'b0, 4'b1110, 8'h00);
        issue(1'b1, 4'b0000, 8'h12);
        issue(1'b0, 4'b1111, 8'h00);
        @(negedge clk);
        check("swp1_reg_a", reg_a, 8'h34);
        check("swp1_in_ready", in_ready, 0);
        load   = 1'b0;
        opcode = 4'b0000;
        result = 8'h77;
        model_push(1'b0, 4'b0000, 8'h77);
        @(negedge clk);
        check("swp2_reg_b", reg_b, 8'h12);
        check("swp2_done", done, 1);
        check("swp2_in_ready", in_ready, 1);
        check("swp2_add_not_taken", reg_a, 8'h34);
        @(negedge clk);
        in_valid = 1'b0;
        check("swp_add_reg_a", reg_a, 8'h77);

        // CMP updates flags only
        issue(1'b1, 4'b0000, 8'h20);
        issue(1'b0, 4'b0100, 8'h00);
        idle();
        check("cmp_reg_a", reg_a, 8'h20);
        check("cmp_flag_z", flag_z, 1);
        check("cmp_flag_n", flag_n, 0);
        issue(1'b0, 4'b0100, 8'h80);
        idle();
        check("cmpn_flag_n", flag_n, 1);
        check("cmpn_flag_z", flag_z, 0);

        // Asynchronous reset while in SWAP2
        issue(1'b0, 4'b1111, 8'h00);
        @(negedge clk);
        in_valid = 1'b0;
        check("abort_in_ready", in_ready, 0);
        #2 rst_n = 1'b0;
        #1;
        check("abort_reg_a", reg_a, 8'h00);
        check("abort_reg_b", reg_b, 8'h00);
        check("abort_flag_z", flag_z, 1);
        check("abort_flag_n", flag_n, 0);
        check("abort_in_ready_rst", in_ready, 1);
        check("abort_done", done, 0);
        sb.delete();
        ma = '0; mb = '0; mz = 1'b1; mn = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("post_abort_done", done, 0);
        check("post_abort_reg_b", reg_b, 8'h00);

        // Swap after reset must see a cleared temp
        issue(1'b1, 4'b0000, 8'h3C);
        issue(1'b0, 4'b1111, 8'h00);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("final_reg_a", reg_a, 8'h00);
        check("final_reg_b", reg_b, 8'h3C);
        check("sb_drained", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
